// File: rtl/mempool_dma_arbiter.sv
// Round-robin arbiter sharing one DMA request port between several frontends,
// with in-order tracking of issued transfers so completions route back to their owner.
//
// state      | meaning
// ARB_FREE   | candidate chosen each cycle by round-robin search from rr_ptr
// ARB_LOCKED | request presented without ready; candidate held until handshake
module mempool_dma_arbiter #(
    parameter int unsigned NumRequesters  = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         dma_req_t      = logic,
    parameter int unsigned IdxW           = (NumRequesters > 1) ? $clog2(NumRequesters) : 1,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  dma_req_t [NumRequesters-1:0]   req_i,
    input  logic     [NumRequesters-1:0]   req_valid_i,
    output logic     [NumRequesters-1:0]   req_ready_o,
    output dma_req_t                       dma_req_o,
    output logic                           dma_req_valid_o,
    input  logic                           dma_req_ready_i,
    input  logic                           dma_done_i,
    output logic     [NumRequesters-1:0]   done_o,
    output logic     [NumRequesters-1:0]   busy_o,
    output logic                           idle_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr, lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] cand, search_idx, rr_next, head;
    logic            found, lock_q, fifo_full, handshake, pop;
    logic [IdxW-1:0] id_fifo [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] total_cnt;
    logic [CntW-1:0] cnt [NumRequesters];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign lock_q    = (state_q == ARB_LOCKED);
    assign fifo_full = (total_cnt == CntW'(MaxOutstanding));

    always_comb begin
        cand       = rr_ptr;
        search_idx = rr_ptr;
        found      = 1'b0;
        for (int i = 0; i < int'(NumRequesters); i++) begin
            search_idx = IdxW'((32'(rr_ptr) + 32'(i)) % NumRequesters);
            if (!found && req_valid_i[search_idx]) begin
                cand  = search_idx;
                found = 1'b1;
            end
        end
        if (lock_q) begin
            cand = lock_idx_q;
        end
    end

    // Locked path ignores fifo_full: total_cnt cannot grow while a request waits.
    assign dma_req_valid_o = lock_q | ((|req_valid_i) & ~fifo_full);
    assign dma_req_o       = req_i[cand];
    assign handshake       = dma_req_valid_o & dma_req_ready_i;
    assign pop             = dma_done_i & (total_cnt != '0);
    assign head            = id_fifo[rd_ptr];
    assign rr_next         = (cand == IdxW'(NumRequesters - 1)) ? '0 : cand + 1'b1;
    assign idle_o          = (total_cnt == '0) & ~dma_req_valid_o;

    always_comb begin
        req_ready_o = '0;
        done_o      = '0;
        busy_o      = '0;
        for (int k = 0; k < int'(NumRequesters); k++) begin
            req_ready_o[k] = handshake & (cand == IdxW'(k));
            done_o[k]      = pop & (head == IdxW'(k));
            busy_o[k]      = (cnt[k] != '0);
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            ARB_FREE: begin
                if (dma_req_valid_o && !dma_req_ready_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = cand;
                end
            end
            ARB_LOCKED: begin
                if (dma_req_ready_i) begin
                    state_d = ARB_FREE;
                end
            end
            default: state_d = ARB_FREE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_FREE;
            lock_idx_q <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            total_cnt  <= '0;
            for (int k = 0; k < int'(NumRequesters); k++) begin
                cnt[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= rr_next;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (handshake && !pop) begin
                total_cnt <= total_cnt + 1'b1;
            end else if (!handshake && pop) begin
                total_cnt <= total_cnt - 1'b1;
            end
            for (int k = 0; k < int'(NumRequesters); k++) begin
                if ((handshake && cand == IdxW'(k)) && !(pop && head == IdxW'(k))) begin
                    cnt[k] <= cnt[k] + 1'b1;
                end else if (!(handshake && cand == IdxW'(k)) && (pop && head == IdxW'(k))) begin
                    cnt[k] <= cnt[k] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_fifo[wr_ptr] <= cand;
        end
    end

    // A completion with nothing outstanding is a protocol error upstream; it is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(dma_done_i && total_cnt == '0))
            else $warning("dma_done_i with no outstanding transfer ignored");
        end
    end

endmodule

// File: tb/tb_mempool_dma_arbiter.sv
// Self-checking bench for mempool_dma_arbiter: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_mempool_dma_arbiter;

    localparam int N = 4;
    localparam int M = 4;

    logic              clk;
    logic              rst_n;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [7:0]        dma_req;
    logic              dma_valid;
    logic              dma_ready;
    logic              dma_done;
    logic [N-1:0]      done;
    logic [N-1:0]      busy;
    logic              idle;

    mempool_dma_arbiter #(
        .NumRequesters (N),
        .MaxOutstanding(M),
        .dma_req_t     (logic [7:0])
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req_data),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .dma_req_o      (dma_req),
        .dma_req_valid_o(dma_valid),
        .dma_req_ready_i(dma_ready),
        .dma_done_i     (dma_done),
        .done_o         (done),
        .busy_o         (busy),
        .idle_o         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: outstanding IDs in issue order, round-robin pointer, lock
    int q[$];
    int m_rr;
    bit m_locked;
    int m_lidx;
    int m_cand;
    bit m_valid, m_hs, m_pop, m_idle;
    logic [N-1:0] m_ready, m_done, m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rr     = 0;
        m_locked = 0;
        m_lidx   = 0;
    endtask

    task automatic model_eval();
        bit found;
        m_cand = m_rr;
        found  = 0;
        if (m_locked) begin
            m_cand  = m_lidx;
            m_valid = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_valid[(m_rr + i) % N]) begin
                    m_cand = (m_rr + i) % N;
                    found  = 1;
                end
            end
            m_valid = found && (q.size() < M);
        end
        m_hs    = m_valid && dma_ready;
        m_ready = m_hs ? (N'(1) << m_cand) : '0;
        m_pop   = dma_done && (q.size() > 0);
        m_done  = m_pop ? (N'(1) << q[0]) : '0;
        m_busy  = '0;
        foreach (q[i]) m_busy[q[i]] = 1'b1;
        m_idle  = (q.size() == 0) && !m_valid;
    endtask

    task automatic model_update();
        if (m_pop) void'(q.pop_front());
        if (m_hs) begin
            q.push_back(m_cand);
            m_rr     = (m_cand + 1) % N;
            m_locked = 0;
        end else if (m_valid) begin
            m_locked = 1;
            m_lidx   = m_cand;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r, input logic d,
                         input logic [N-1:0][7:0] p);
        @(negedge clk);
        req_valid = v;
        dma_ready = r;
        dma_done  = d;
        req_data  = p;
        #1;
        model_eval();
        chk("ready", 32'(req_ready), 32'(m_ready));
        chk("valid", 32'(dma_valid), 32'(m_valid));
        chk("done",  32'(done),      32'(m_done));
        chk("busy",  32'(busy),      32'(m_busy));
        chk("idle",  32'(idle),      32'(m_idle));
        if (m_valid) chk("data", 32'(dma_req), 32'(p[m_cand]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    task automatic step(input logic [N-1:0] v, input logic r, input logic d,
                        input logic [N-1:0][7:0] p);
        drive(v, r, d, p);
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        dma_ready = 1'b0;
        dma_done  = 1'b0;
        #1;
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_idle",  32'(idle),      32'h1);
        chk("rst_valid", 32'(dma_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_done",  32'(done),      32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic         r;
        logic         d;
        logic [N-1:0] e_rdy;
        logic         e_val;
        logic [N-1:0] e_done;
        logic [N-1:0] e_busy;
        logic         e_idle;
        logic [7:0]   e_data;
    } vec_t;

    vec_t tbl [14];
    logic [N-1:0][7:0] fixed_p;
    logic [N-1:0][7:0] cur_p;

    initial begin
        // single request, completion, then lock under backpressure
        tbl[0]  = '{4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h00};
        tbl[1]  = '{4'b0001, 1, 0, 4'b0001, 1, 4'b0000, 4'b0000, 0, 8'h11};
        tbl[2]  = '{4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 4'b0001, 0, 8'h00};
        tbl[3]  = '{4'b0000, 0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 8'h00};
        tbl[4]  = '{4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h00};
        tbl[5]  = '{4'b0100, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h33};
        tbl[6]  = '{4'b0100, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h33};
        tbl[7]  = '{4'b0100, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h33};
        tbl[8]  = '{4'b0101, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h33};
        tbl[9]  = '{4'b0101, 1, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0, 8'h33};
        tbl[10] = '{4'b0101, 1, 0, 4'b0001, 1, 4'b0000, 4'b0100, 0, 8'h11};
        tbl[11] = '{4'b0000, 0, 1, 4'b0000, 0, 4'b0100, 4'b0101, 0, 8'h00};
        tbl[12] = '{4'b0000, 0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 8'h00};
        tbl[13] = '{4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 1, 8'h00};

        fixed_p   = {8'h44, 8'h33, 8'h22, 8'h11};
        req_data  = fixed_p;
        req_valid = '0;
        dma_ready = 1'b0;
        dma_done  = 1'b0;
        rst_n     = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].d, fixed_p);
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(dma_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d_done", i),  32'(done),      32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_busy", i),  32'(busy),      32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_idle", i),  32'(idle),      32'(tbl[i].e_idle));
            if (tbl[i].e_val) chk($sformatf("tbl%0d_data", i), 32'(dma_req), 32'(tbl[i].e_data));
            tick();
        end

        // round robin with all requesters valid; completions keep one transfer in flight
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, 1'b1, (i > 0), fixed_p);
            chk("rr_grant", 32'(req_ready), 32'(1 << (i % N)));
            if (i > 0) chk("rr_done", 32'(done), 32'(1 << ((i - 1) % N)));
            tick();
        end
        step(4'b0000, 1'b0, 1'b1, fixed_p);

        // full FIFO: four issues from requester 0, then requester 1 must wait
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b1, 1'b0, fixed_p);
        drive(4'b0010, 1'b1, 1'b0, fixed_p);
        chk("full_valid", 32'(dma_valid), 32'h0);
        chk("full_ready", 32'(req_ready), 32'h0);
        tick();
        drive(4'b0010, 1'b1, 1'b1, fixed_p);
        chk("full_done_valid", 32'(dma_valid), 32'h0);
        chk("full_done",       32'(done),      32'h1);
        tick();
        drive(4'b0010, 1'b1, 1'b0, fixed_p);
        chk("full_after_grant", 32'(req_ready), 32'h2);
        tick();
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0, 1'b1, fixed_p);
        drive(4'b0000, 1'b0, 1'b0, fixed_p);
        chk("drain_idle", 32'(idle), 32'h1);
        tick();

        // handshake and completion for the same requester in one cycle
        step(4'b1000, 1'b1, 1'b0, fixed_p);
        drive(4'b1000, 1'b1, 1'b1, fixed_p);
        chk("sim_done",  32'(done),      32'h8);
        chk("sim_ready", 32'(req_ready), 32'h8);
        tick();
        drive(4'b0000, 1'b0, 1'b0, fixed_p);
        chk("sim_busy", 32'(busy), 32'h8);
        tick();
        step(4'b0000, 1'b0, 1'b1, fixed_p);
        drive(4'b0000, 1'b0, 1'b0, fixed_p);
        chk("sim_busy_clr", 32'(busy), 32'h0);
        chk("sim_idle",     32'(idle), 32'h1);
        tick();
        drive(4'b0000, 1'b0, 1'b1, fixed_p);
        chk("empty_done", 32'(done), 32'h0);
        tick();

        // reset with two transfers outstanding discards tracking
        step(4'b0011, 1'b1, 1'b0, fixed_p);
        step(4'b0011, 1'b1, 1'b0, fixed_p);
        drive(4'b0000, 1'b0, 1'b0, fixed_p);
        chk("pre_rst_busy", 32'(busy), 32'h3);
        tick();
        do_reset();
        drive(4'b0000, 1'b0, 1'b1, fixed_p);
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_idle", 32'(idle), 32'h1);
        tick();

        // randomized traffic; a locked requester keeps valid and payload stable
        cur_p = fixed_p;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] v;
            logic r, d;
            for (int k = 0; k < N; k++) begin
                if (m_locked && k == m_lidx) begin
                    v[k] = 1'b1;
                end else begin
                    v[k]     = ($urandom_range(0, 99) < 40);
                    cur_p[k] = 8'($urandom);
                end
            end
            r = ($urandom_range(0, 99) < 60);
            d = (q.size() > 0) && ($urandom_range(0, 99) < 35);
            step(v, r, d, cur_p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
